// File: rtl/posit_div.sv
// Sequential posit32 (es=3) divider: unpack, subtract scales, restoring divide, round, repack.
// Optional POSIT_DIV_EARLY_EXIT_EN skips the divide loop when the divisor is a power of two.
module posit_div #(
  parameter int QW = 30,
  parameter int ES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] posit_a,
  input  logic [31:0] posit_b,
  output logic [31:0] posit_result,
  output logic        done,
  output logic        busy,
  output logic        NAR,
  output logic        ZERO
);

  localparam int FW = QW - 1;
  localparam int WW = 2 + ES + FW + 31;
  localparam int CW = $clog2(QW);

  typedef struct packed {
    logic              sign;
    logic signed [9:0] scale;
    logic [26:0]       mant;
  } dec_t;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_DIVIDE, S_NORM, S_ENCODE} state_t;

  function automatic dec_t f_decode(input logic [31:0] p);
    dec_t        d;
    logic [30:0] mag;
    logic [28:0] rest;
    int          m;
    int          k;
    logic        run;
    mag = p[31] ? 31'(-p) : p[30:0];
    m   = 0;
    run = 1'b1;
    for (int i = 30; i >= 0; i--) begin
      if (run && (mag[i] == mag[30])) m++;
      else run = 1'b0;
    end
    // Drop the regime run and its terminator; what is left is exponent then fraction.
    rest    = mag[28:0] << (m - 1);
    k       = mag[30] ? (m - 1) : -m;
    d.sign  = p[31];
    d.scale = 10'(k * (1 << ES) + int'(rest[28 -: ES]));
    d.mant  = {1'b1, rest[28-ES:0]};
    return d;
  endfunction

  function automatic logic [31:0] f_encode(input logic sign, input logic signed [9:0] scale,
                                           input logic [FW-1:0] frac, input logic sticky);
    logic signed [9:0]    k;
    int                   n;
    logic signed [WW-1:0] w;
    logic [30:0]          mag;
    logic [31:0]          sum;
    logic                 g;
    logic                 st;
    k = scale >>> ES;
    n = (k >= 0) ? int'(k) : (-int'(k) - 1);
    // Arithmetic shift stretches the 2-bit regime seed with copies of its leading bit.
    w   = {((k >= 0) ? 2'b10 : 2'b01), scale[ES-1:0], frac, 31'b0};
    w   = w >>> n;
    mag = w[WW-1 -: 31];
    g   = w[WW-32];
    st  = sticky | (|w[WW-33:0]);
    sum = {1'b0, mag} + {31'b0, g & (st | mag[0])};
    if (scale > 10'sd240)       mag = '1;
    else if (scale < -10'sd240) mag = 31'd1;
    else if (sum[31])           mag = '1;
    else                        mag = sum[30:0];
    return sign ? -{1'b0, mag} : {1'b0, mag};
  endfunction

  state_t            r_state;
  logic [31:0]       r_a, r_b;
  logic              r_sign, r_nar, r_zero, r_sticky;
  logic signed [9:0] r_scale;
  logic [27:0]       r_rem;
  logic [26:0]       r_div;
  logic [QW-1:0]     r_q;
  logic [CW-1:0]     r_cnt;

  dec_t w_da, w_db;
  logic w_nar, w_zero;

  assign w_da   = f_decode(r_a);
  assign w_db   = f_decode(r_b);
  assign w_nar  = (r_a == 32'h8000_0000) || (r_b == 32'h8000_0000) || (r_b == 32'h0);
  assign w_zero = (r_a == 32'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      posit_result <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      NAR          <= 1'b0;
      ZERO         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= posit_a;
          r_b     <= posit_b;
          busy    <= 1'b1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_nar   <= w_nar;
          r_zero  <= w_zero;
          r_sign  <= w_da.sign ^ w_db.sign;
          r_scale <= w_da.scale - w_db.scale;
          r_rem   <= {1'b0, w_da.mant};
          r_div   <= w_db.mant;
          r_cnt   <= CW'(QW - 1);
          r_q     <= '0;
          if (w_nar || w_zero) r_state <= S_ENCODE;
`ifdef POSIT_DIV_EARLY_EXIT_EN
          else if (w_db.mant[25:0] == 26'd0) begin
            r_q     <= {w_da.mant, {(QW-27){1'b0}}};
            r_rem   <= '0;
            r_state <= S_NORM;
          end
`endif
          else r_state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          if (r_rem >= {1'b0, r_div}) begin
            r_rem <= (r_rem - {1'b0, r_div}) << 1;
            r_q   <= {r_q[QW-2:0], 1'b1};
          end else begin
            r_rem <= r_rem << 1;
            r_q   <= {r_q[QW-2:0], 1'b0};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_NORM;
        end
        S_NORM: begin
          r_sticky <= |r_rem;
          if (!r_q[QW-1]) begin
            r_q     <= r_q << 1;
            r_scale <= r_scale - 10'sd1;
          end
          r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          posit_result <= r_nar  ? 32'h8000_0000 :
                          r_zero ? 32'h0 : f_encode(r_sign, r_scale, r_q[QW-2:0], r_sticky);
          NAR     <= r_nar;
          ZERO    <= !r_nar && r_zero;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
